// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module   : serial_adder_pkg
// Purpose  : Shared types and helpers for the serial adder.
//            - FSM state encoding (IDLE, RUN, DONE).
//            - Elaboration-time parameter check for WIDTH/DIGIT.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // True when WIDTH/DIGIT form a legal configuration: at least two operand
  // bits, and a digit size that splits the operand into whole digits.
  function automatic bit width_ok(input int width, input int digit);
    return (width >= 2) && (digit >= 1) && (digit <= width) &&
           ((width % digit) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_adder_if.sv
// ============================================================================
// Module   : serial_adder_if
// Purpose  : Request/result bundle between a requester and the serial adder.
// Ports    : start, a, b, cin, sub   requester -> adder
//            busy, done              adder status
//            sout, cout, stotal      registered result ({cout, sout})
// Modports : master (requester side), slave (adder side)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_adder_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sout;
  logic             cout;
  logic [WIDTH:0]   stotal;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sout, cout, stotal
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sout, cout, stotal
  );

endinterface

`default_nettype wire

// File: rtl/serial_adder_fa_digit.sv
// ============================================================================
// Module   : fa_digit
// Purpose  : Purely combinational DIGIT-bit ripple adder built from 1-bit
//            full-adder equations.
// Ports    : x, y [DIGIT-1:0]  addends
//            ci                carry in
//            s  [DIGIT-1:0]    sum
//            co                carry out
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fa_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  // The carry ripples through a procedural temporary rather than a carry
  // vector, so the chain is not seen as a self-referencing net.
  logic carry_v;

  always_comb begin
    s       = '0;
    carry_v = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]    = x[i] ^ y[i] ^ carry_v;
      carry_v = (x[i] & y[i]) | (carry_v & (x[i] ^ y[i]));
    end
    co = carry_v;
  end

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module   : serial_adder
// Purpose  : Multi-cycle adder: stotal = a + b + cin, DIGIT bits per clock
//            through a registered carry, with a start/busy/done handshake.
//            Latency from accepted start to done is WIDTH/DIGIT + 1 cycles.
// Ports    : clk        rising-edge clock
//            rst        synchronous active-high reset
//            bus        serial_adder_if.slave (start/a/b/cin/sub in,
//                       busy/done/sout/cout/stotal out)
// Config   : SERIAL_ADDER_SUB_EN - when defined, a captured sub=1 makes the
//            block compute a - b (cout=1 means no borrow). When undefined
//            sub is ignored and the block always adds.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic          clk,
  input logic          rst,
  serial_adder_if.slave bus
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if (!width_ok(WIDTH, DIGIT)) begin : g_bad_cfg
    $error("serial_adder: WIDTH must be >= 2 and an exact multiple of DIGIT");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh, r_nxt;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sout_q;
  logic             cout_q;

  logic [DIGIT-1:0] dsum;
  logic             dco;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

`ifdef SERIAL_ADDER_SUB_EN
  // a - b as a + ~b + 1: invert B and force the initial carry.
  assign b_load = bus.sub ? ~bus.b : bus.b;
  assign c_load = bus.sub ? 1'b1   : bus.cin;
`else
  logic unused_sub;
  assign unused_sub = bus.sub;
  assign b_load     = bus.b;
  assign c_load     = bus.cin;
`endif

  fa_digit #(
    .DIGIT (DIGIT)
  ) u_fa_digit (
    .x  (a_sh[DIGIT-1:0]),
    .y  (b_sh[DIGIT-1:0]),
    .ci (carry),
    .s  (dsum),
    .co (dco)
  );

  // Each digit enters at the MSB end, so after N digits the first one has
  // reached bit 0. With a single digit the result is just that digit.
  if (DIGIT == WIDTH) begin : g_single_digit
    assign r_nxt = dsum;
  end else begin : g_multi_digit
    assign r_nxt = {dsum, r_sh[WIDTH-1:DIGIT]};
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sout_q <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh  <= bus.a;
            b_sh  <= b_load;
            carry <= c_load;
            r_sh  <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          r_sh  <= r_nxt;
          carry <= dco;
          cnt   <= cnt + CNT_W'(1);
          // Visible outputs update only once the whole sum is known.
          if (cnt == LAST) begin
            sout_q <= r_nxt;
            cout_q <= dco;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state == RUN);
  assign bus.done   = (state == DONE);
  assign bus.sout   = sout_q;
  assign bus.cout   = cout_q;
  assign bus.stotal = {cout_q, sout_q};

endmodule

`default_nettype wire

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder for the combinational-circuits datapath. It adds two WIDTH-bit operands plus carry-in, processing DIGIT bits per clock through a registered carry. A start/busy/done handshake reports completion, and the sum is returned in the same sout/cout/stotal form the single-bit full adder uses. It trades latency for area where a wide ripple adder is too costly, and it is the sequential successor to the 1-bit full-adder cell.

## Interface
- WIDTH, default 8: operand width in bits; must be ≥ 2.
- DIGIT, default 1: bits processed per cycle; must divide WIDTH exactly. N = WIDTH/DIGIT.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  operand A; captured on an accepted start
- b  in  WIDTH  operand B; captured on an accepted start
- cin  in  1  carry-in; captured on an accepted start
- sub  in  1  subtract request; captured on an accepted start; ignored unless SERIAL_ADDER_SUB_EN is defined
- busy  out  1  high while the RUN state is active
- done  out  1  one-cycle pulse when the result registers update
- sout  out  WIDTH  registered sum
- cout  out  1  registered carry-out
- stotal  out  WIDTH+1  {cout, sout}

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 loads the operand shift registers with a and b, the carry register with cin, and the digit counter with 0.
  - Next state is RUN.
- RUN, each cycle:
  - Digit result = a_sh[DIGIT-1:0] + b_sh[DIGIT-1:0] + carry, computed (DIGIT+1) bits wide.
  - The low DIGIT bits shift into the MSB end of the internal result shift register.
  - Bit DIGIT of the digit result becomes the new carry.
  - Both operand registers shift right by DIGIT.
  - The counter increments.
  - When the counter reaches N-1, the final result loads into sout and cout, and next state is DONE.
- DONE: done=1 for exactly one cycle, then unconditional return to IDLE.
- Outputs sout, cout and stotal hold their last result until the next completion. They never show partial sums.
- start while in RUN or DONE is ignored. There is no queueing and no second done pulse.
- Arithmetic: stotal = a + b + cin, exact in WIDTH+1 bits. Wrap-around appears only as cout=1.
- Reset mid-operation: the operation is aborted with no done pulse, and the captured operands are discarded.

## Timing
- Reset values:
  - State is IDLE.
  - busy=0, done=0, sout=0, cout=0, stotal=0.
  - Internal registers are 0.
- Cycle numbering: start is sampled high at edge k.
  - busy=1 for cycles k+1 … k+N.
  - done=1 and the new sout/cout are visible in cycle k+N+1.
- Latency from start to done is N+1 cycles. For WIDTH=8: 9 cycles at DIGIT=1, 3 cycles at DIGIT=4.
- Back-to-back throughput: a new start is accepted in cycle k+N+2 at the earliest.
- Operands may change freely after the accepting edge.
- rst has priority over start in the same cycle.

## Configuration
- SERIAL_ADDER_SUB_EN defined: when sub is captured as 1, the block computes a − b.
  - The B shift register loads ~b.
  - The carry register loads 1; cin is ignored.
  - cout=1 means no borrow; cout=0 means borrow.
- SERIAL_ADDER_SUB_EN undefined: the sub port exists but is ignored, and the block always adds.

## Structure
- Package serial_adder_pkg holds:
  - the state enum typedef (IDLE, RUN, DONE);
  - a width-check function that validates WIDTH % DIGIT == 0 and is used in an elaboration-time assertion.
- Sub-module fa_digit is a purely combinational DIGIT-bit ripple adder built from 1-bit full-adder equations.
  - Inputs: x, y, ci. Outputs: s, co.
  - The top level contains only the FSM, the counter and the registers.

## Test plan
- WIDTH=8, DIGIT=1, a=0x00, b=0x00, cin=0 → done in cycle k+9; sout=0x00, cout=0, stotal=0x000; busy high for exactly 8 cycles.
- a=0xFF, b=0x01, cin=0 → sout=0x00, cout=1, stotal=0x100.
- a=0xFF, b=0xFF, cin=1 → sout=0xFF, cout=1, stotal=0x1FF.
- start held high through the operation, with a/b changed to 0x11/0x22 after acceptance of a=0x0F, b=0x01 → exactly one done pulse; sout=0x10; the second request is never processed.
- rst pulsed in the 4th RUN cycle of a=0xAA, b=0x55 → busy=0 and done=0 next cycle; sout=0 and cout=0; no done pulse. A following a=0x01, b=0x02 yields sout=0x03.
- DIGIT=4, a=0x3C, b=0x0F, cin=0 → done at k+3, sout=0x4B, cout=0. With SERIAL_ADDER_SUB_EN defined, sub=1, a=0x05, b=0x07 → sout=0xFE, cout=0 (borrow).
